// File: rtl/vec2_result_collector.sv
// Captures the (x, y) float result burst, converts each word to signed fixed point,
// buffers the pair in a show-ahead FIFO and acknowledges the producer once it is stored.
module vec2_result_collector #(
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 4,
  parameter int DEPTH     = 4
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic                         calc_done,
  input  logic [31:0]                  result,
  output logic                         read_done,
  output logic                         vtx_valid,
  input  logic                         vtx_ready,
  output logic [OUT_W-1:0]             vtx_x,
  output logic [OUT_W-1:0]             vtx_y,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         proto_err,
  input  logic                         err_clr
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, CAP_Y, CONV, PUSH, ACK} state_t;
  state_t state, state_nxt;

  logic [31:0]                  x_raw, y_raw;
  logic [OUT_W-1:0]             x_cv, y_cv;
  logic [DEPTH-1:0][2*OUT_W-1:0] mem;
  logic [PW-1:0]                wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0]                cnt_nxt;
  logic                         full, push, pop, err_set;

  // Float -> fixed; the 64-bit magnitude plus the early cut-off keeps huge exponents from wrapping.
  function automatic logic [OUT_W-1:0] conv(input logic [31:0] f);
    logic [7:0]       e;
    logic [23:0]      m;
    logic [63:0]      mag;
    logic [63:0]      lim_p, lim_n;
    logic [OUT_W-1:0] vmax, vmin;
    int               sh;
    e     = f[30:23];
    m     = {1'b1, f[22:0]};
    sh    = int'(e) - 127 + FRAC_BITS - 23;
    lim_n = 64'd1 << (OUT_W-1);
    lim_p = lim_n - 64'd1;
    vmax  = {1'b0, {(OUT_W-1){1'b1}}};
    vmin  = {1'b1, {(OUT_W-1){1'b0}}};
    if (sh >= 40)       mag = '1;
    else if (sh >= 0)   mag = {40'd0, m} << sh[5:0];
    else if (sh > -24)  mag = {40'd0, m} >> 6'(-sh);
    else                mag = '0;
    if (e == 8'hFF)     conv = (f[22:0] != 23'd0) ? '0 : (f[31] ? vmin : vmax);
    else if (e == 8'h0) conv = '0;
    else if (f[31])     conv = (mag >= lim_n) ? vmin : -mag[OUT_W-1:0];
    else                conv = (mag >  lim_p) ? vmax :  mag[OUT_W-1:0];
  endfunction

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (calc_done) state_nxt = CAP_Y;
      CAP_Y:   state_nxt = calc_done ? CONV : IDLE;
      CONV:    state_nxt = PUSH;
      PUSH:    if (!full) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    read_done = (state == ACK);
    push      = (state == PUSH) && !full;
    err_set   = ((state == CAP_Y) && !calc_done) ||
                (calc_done && (state == CONV || state == PUSH || state == ACK));
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      x_raw <= '0;
      y_raw <= '0;
      x_cv  <= '0;
      y_cv  <= '0;
    end else begin
      if (state == IDLE  && calc_done) x_raw <= result;
      if (state == CAP_Y && calc_done) y_raw <= result;
      if (state == CONV) begin
        x_cv <= conv(x_raw);
        y_cv <= conv(y_raw);
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)         proto_err <= 1'b0;
    else if (err_set) proto_err <= 1'b1;
    else if (err_clr) proto_err <= 1'b0;
  end

  assign full    = (fifo_count == CW'(DEPTH));
  assign pop     = vtx_valid & vtx_ready;
  assign rd_nxt  = pop ? rd_ptr + PW'(1) : rd_ptr;
  assign cnt_nxt = fifo_count + CW'(push) - CW'(pop);

  always_ff @(posedge iClk) begin
    if (push) mem[wr_ptr] <= {y_cv, x_cv};
  end

  // Head is registered so it can hold its last value once the FIFO drains.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      vtx_valid  <= 1'b0;
      vtx_x      <= '0;
      vtx_y      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr     <= rd_nxt;
      fifo_count <= cnt_nxt;
      vtx_valid  <= (cnt_nxt != '0);
      if (cnt_nxt != '0) begin
        if (push && wr_ptr == rd_nxt) {vtx_y, vtx_x} <= {y_cv, x_cv};
        else                          {vtx_y, vtx_x} <= mem[rd_nxt];
      end
    end
  end
endmodule

// File: tb/tb_vec2_result_collector.sv
// Directed bench for vec2_result_collector: timing, conversion, backpressure, errors, reset.
module tb_vec2_result_collector;
  localparam int OUT_W = 16;
  localparam int FRAC  = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic              iClk = 1'b0;
  logic              iRst;
  logic              calc_done;
  logic [31:0]       result;
  logic              read_done;
  logic              vtx_valid;
  logic              vtx_ready;
  logic [OUT_W-1:0]  vtx_x, vtx_y;
  logic [CW-1:0]     fifo_count;
  logic              proto_err;
  logic              err_clr;

  int checks   = 0;
  int failures = 0;

  vec2_result_collector #(.OUT_W(OUT_W), .FRAC_BITS(FRAC), .DEPTH(DEPTH)) dut (
    .iClk(iClk), .iRst(iRst), .calc_done(calc_done), .result(result),
    .read_done(read_done), .vtx_valid(vtx_valid), .vtx_ready(vtx_ready),
    .vtx_x(vtx_x), .vtx_y(vtx_y), .fifo_count(fifo_count),
    .proto_err(proto_err), .err_clr(err_clr)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Float bits of +/-n for small positive n, and its expected fixed-point value.
  function automatic logic [31:0] mkf(input int n, input bit neg);
    int          msb;
    logic [31:0] un;
    msb = 0;
    for (int b = 0; b < 24; b++) if (n[b]) msb = b;
    un = 32'(n) << (23 - msb);
    return {neg, 8'(127 + msb), un[22:0]};
  endfunction

  function automatic logic [15:0] mkx(input int n, input bit neg);
    return neg ? 16'(-(n * 16)) : 16'(n * 16);
  endfunction

  // Ends in the middle of cycle T+2 with calc_done low again.
  task automatic burst(input logic [31:0] x, input logic [31:0] y);
    @(negedge iClk); calc_done = 1'b1; result = x;
    @(negedge iClk); result = y;
    @(negedge iClk); calc_done = 1'b0; result = '0;
  endtask

  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    while (!read_done && n < 8) begin
      @(negedge iClk);
      n++;
    end
    chk(tag, read_done, 1);
  endtask

  task automatic burst_check(input string tag, input logic [31:0] x, input logic [31:0] y,
                             input logic [15:0] ex, input logic [15:0] ey);
    burst(x, y);
    wait_ack({tag, "_ack"});
    chk({tag, "_valid"}, vtx_valid, 1);
    chk({tag, "_x"}, vtx_x, ex);
    chk({tag, "_y"}, vtx_y, ey);
  endtask

  task automatic no_ack(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge iClk);
      if (read_done) seen = 1'b1;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] e;
    iRst = 1'b1; calc_done = 1'b0; result = '0; vtx_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge iClk);
    chk("rst_read_done", read_done, 0);
    chk("rst_valid", vtx_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_x", vtx_x, 0);
    chk("rst_y", vtx_y, 0);
    chk("rst_err", proto_err, 0);
    iRst = 1'b0;

    // single burst, exact latency
    vtx_ready = 1'b1;
    burst(32'h3FC00000, 32'hC0100000);
    chk("t1_rd_T2", read_done, 0);
    @(negedge iClk);
    chk("t1_rd_T3", read_done, 0);
    chk("t1_valid_T3", vtx_valid, 0);
    @(negedge iClk);
    chk("t1_rd_T4", read_done, 1);
    chk("t1_valid_T4", vtx_valid, 1);
    chk("t1_x", vtx_x, 16'h0018);
    chk("t1_y", vtx_y, 16'hFFDC);
    chk("t1_count1", fifo_count, 1);
    @(negedge iClk);
    chk("t1_count0", fifo_count, 0);
    chk("t1_valid0", vtx_valid, 0);
    chk("t1_rd_T5", read_done, 0);
    chk("t1_x_hold", vtx_x, 16'h0018);

    // saturation and special values
    burst_check("sat",  32'h459C4000, 32'hC59C4000, 16'h7FFF, 16'h8000);
    burst_check("nan",  32'h7FC00000, 32'h00000001, 16'h0000, 16'h0000);
    burst_check("inf",  32'hFF800000, 32'h3D800000, 16'h8000, 16'h0001);
    burst_check("huge", 32'h7F7FFFFF, 32'h80000000, 16'h7FFF, 16'h0000);
    @(negedge iClk);

    // backpressure
    vtx_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      burst(mkf(i, 0), mkf(i, 1));
      wait_ack("bp_ack");
    end
    @(negedge iClk);
    chk("bp_full", fifo_count, DEPTH);
    chk("bp_head", vtx_x, mkx(1, 0));
    burst(mkf(DEPTH+1, 0), mkf(DEPTH+1, 1));
    no_ack("bp_blocked", 6);
    chk("bp_still_full", fifo_count, DEPTH);
    vtx_ready = 1'b1;
    @(negedge iClk);
    vtx_ready = 1'b0;
    chk("bp_after_pop_cnt", fifo_count, DEPTH-1);
    chk("bp_after_pop_rd", read_done, 0);
    @(negedge iClk);
    chk("bp_push_cnt", fifo_count, DEPTH);
    chk("bp_push_rd", read_done, 1);
    vtx_ready = 1'b1;
    for (int i = 2; i <= DEPTH+1; i++) begin
      chk("bp_drain_x", vtx_x, mkx(i, 0));
      chk("bp_drain_y", vtx_y, mkx(i, 1));
      @(negedge iClk);
    end
    chk("bp_empty", vtx_valid, 0);
    chk("bp_hold", vtx_x, mkx(DEPTH+1, 0));

    // simultaneous push/pop with pointer wrap
    vtx_ready = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      burst(mkf(i, 0), mkf(i, 1));
      wait_ack("pp_fill");
      q.push_back({mkx(i, 1), mkx(i, 0)});
    end
    for (int i = 3; i < 3 + 3*DEPTH; i++) begin
      burst(mkf(i, 0), mkf(i, 1));
      @(negedge iClk);
      vtx_ready = 1'b1;
      @(negedge iClk);
      vtx_ready = 1'b0;
      void'(q.pop_front());
      q.push_back({mkx(i, 1), mkx(i, 0)});
      e = q[0];
      chk("pp_rd", read_done, 1);
      chk("pp_cnt", fifo_count, 2);
      chk("pp_head", {vtx_y, vtx_x}, e);
    end
    vtx_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      e = q.pop_front();
      chk("pp_drain", {vtx_y, vtx_x}, e);
      @(negedge iClk);
    end
    chk("pp_empty", fifo_count, 0);

    // protocol errors
    @(negedge iClk); calc_done = 1'b1; result = mkf(7, 0);
    @(negedge iClk); calc_done = 1'b0;
    @(negedge iClk);
    chk("pe_set", proto_err, 1);
    no_ack("pe_no_ack", 4);
    chk("pe_no_write", fifo_count, 0);
    burst_check("pe_next", mkf(1, 0), mkf(1, 1), 16'h0010, 16'hFFF0);
    chk("pe_sticky", proto_err, 1);
    @(negedge iClk); err_clr = 1'b1;
    @(negedge iClk); err_clr = 1'b0;
    chk("pe_clr", proto_err, 0);
    @(negedge iClk); calc_done = 1'b1;
    @(negedge iClk); calc_done = 1'b0; err_clr = 1'b1;
    @(negedge iClk); err_clr = 1'b0;
    chk("pe_set_wins", proto_err, 1);
    @(negedge iClk); err_clr = 1'b1;
    @(negedge iClk); err_clr = 1'b0;
    @(negedge iClk); calc_done = 1'b1; result = mkf(2, 0);
    @(negedge iClk); result = mkf(3, 1);
    @(negedge iClk); result = 32'h7F800000;
    @(negedge iClk); calc_done = 1'b0;
    @(negedge iClk);
    chk("pe_conv_rd", read_done, 1);
    chk("pe_conv_x", vtx_x, mkx(2, 0));
    chk("pe_conv_y", vtx_y, mkx(3, 1));
    chk("pe_conv_err", proto_err, 1);
    @(negedge iClk);

    // reset during CONV, then during PUSH
    vtx_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 1; i <= 2; i++) begin
        burst(mkf(i, 0), mkf(i, 1));
        wait_ack("rs_fill");
      end
      @(negedge iClk);
      chk("rs_cnt2", fifo_count, 2);
      burst(mkf(9, 0), mkf(9, 1));
      if (k == 1) @(negedge iClk);
      iRst = 1'b1;
      #1;
      chk("rs_valid", vtx_valid, 0);
      chk("rs_cnt", fifo_count, 0);
      chk("rs_rd", read_done, 0);
      chk("rs_err", proto_err, 0);
      @(negedge iClk); iRst = 1'b0;
      no_ack("rs_no_ack", 5);
      chk("rs_cnt_after", fifo_count, 0);
    end
    vtx_ready = 1'b1;
    burst_check("rs_next", mkf(5, 0), mkf(6, 1), mkx(5, 0), mkx(6, 1));
    @(negedge iClk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
